spart: RTL and testbench

- Special-purpose UART, directly downstream of the processor-side bus driver.
- Decodes the 8-bit bidirectional databus (iocs/iorw/ioaddr) into a transmit buffer, receive buffer, status register and a 16-bit baud divisor.
- Serialises and deserialises 8N1 frames on txd/rxd.
- Handshakes back to the driver via rda (receive data available) and tbr (transmit buffer ready).

---
 rtl/spart_pkg.sv | 14 +
 rtl/spart_baud_gen.sv | 38 +++
 rtl/spart.sv | 169 ++++++++++++++++
 tb/tb_spart.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared register map, FSM state types and default oversampling ratio for the SPART.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud-enable generator: en pulses once every divisor+1 clocks.
module spart_baud_gen #(
    parameter logic [15:0] RST_DIVISOR = 16'd325
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_dbl,
    input  logic       wr_dbh,
    input  logic [7:0] wr_data,
    output logic       en
);

    logic [15:0] divisor;
    logic [15:0] count;
    logic        reload_pending;

    assign en = (count == 16'd0);

    // A high-byte write restarts the count from the complete new divisor one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor        <= RST_DIVISOR;
            count          <= RST_DIVISOR;
            reload_pending <= 1'b0;
        end else begin
            reload_pending <= wr_dbh;
            if (wr_dbl)
                divisor[7:0] <= wr_data;
            if (wr_dbh)
                divisor[15:8] <= wr_data;
            if (reload_pending || count == 16'd0)
                count <= divisor;
            else
                count <= count - 16'd1;
        end
    end

endmodule

// File: rtl/spart.sv
// Special-purpose UART: bus register decode plus 8N1 transmitter and receiver.
module spart
    import spart_pkg::*;
#(
    parameter int          OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter logic [15:0] RST_DIVISOR = 16'd325,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam int            OSW     = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);

    logic       baud_en;
    logic       wr_buf, wr_dbl, wr_dbh, rd_buf, bus_oe;
    logic [7:0] rd_data;
    logic [7:0] rx_buf;

    assign wr_buf = iocs && !iorw && (ioaddr == ADDR_BUF);
    assign wr_dbl = iocs && !iorw && (ioaddr == ADDR_DBL);
    assign wr_dbh = iocs && !iorw && (ioaddr == ADDR_DBH);
    assign rd_buf = iocs && iorw && (ioaddr == ADDR_BUF);
    assign bus_oe = iocs && iorw && ((ioaddr == ADDR_BUF) || (ioaddr == ADDR_STAT));

    assign rd_data = (ioaddr == ADDR_BUF) ? rx_buf : {6'b0, tbr, rda};
    assign databus = bus_oe ? rd_data : 8'bzzzz_zzzz;

    spart_baud_gen #(.RST_DIVISOR(RST_DIVISOR)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_dbl  (wr_dbl),
        .wr_dbh  (wr_dbh),
        .wr_data (databus),
        .en      (baud_en)
    );

    tx_state_t      tx_state;
    logic [7:0]     tx_shift;
    logic [OSW-1:0] tx_os;
    logic [2:0]     tx_bit;

    // tbr low means a byte is loaded or in flight; the FSM only starts on an enable pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_os    <= '0;
            tx_bit   <= '0;
            tbr      <= 1'b1;
            txd      <= 1'b1;
        end else begin
            if (wr_buf && tbr) begin
                tx_shift <= databus;
                tbr      <= 1'b0;
            end
            if (baud_en) begin
                case (tx_state)
                    TX_IDLE: if (!tbr) begin
                        tx_state <= TX_START;
                        txd      <= 1'b0;
                        tx_os    <= '0;
                    end
                    TX_START: if (tx_os == OS_LAST) begin
                        tx_state <= TX_DATA;
                        txd      <= tx_shift[0];
                        tx_os    <= '0;
                        tx_bit   <= '0;
                    end else tx_os <= tx_os + 1'b1;
                    TX_DATA: if (tx_os == OS_LAST) begin
                        tx_os <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= tx_shift >> 1;
                            txd      <= tx_shift[1];
                        end
                    end else tx_os <= tx_os + 1'b1;
                    TX_STOP: if (tx_os == OS_LAST) begin
                        tx_state <= TX_IDLE;
                        tbr      <= 1'b1;
                    end else tx_os <= tx_os + 1'b1;
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_s, rx_prev, rx_ferr;
    rx_state_t              rx_state;
    logic [7:0]             rx_shift;
    logic [OSW-1:0]         rx_os;
    logic [2:0]             rx_bit;

    assign rx_s = rx_sync[SYNC_STAGES-1];

    // A completed byte sets rda after any read clear, so a same-cycle completion wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync  <= '1;
            rx_prev  <= 1'b1;
            rx_ferr  <= 1'b0;
            rx_state <= RX_IDLE;
            rx_shift <= '0;
            rx_os    <= '0;
            rx_bit   <= '0;
            rx_buf   <= '0;
            rda      <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], rxd};
            rx_prev <= rx_s;
            if (rd_buf)
                rda <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s) begin
                    rx_state <= RX_START;
                    rx_os    <= '0;
                end
                RX_START: if (baud_en) begin
                    if (rx_os == OS_MID) begin
                        rx_os  <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else rx_os <= rx_os + 1'b1;
                end
                RX_DATA: if (baud_en) begin
                    if (rx_os == OS_LAST) begin
                        rx_os    <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                    end else rx_os <= rx_os + 1'b1;
                end
                RX_STOP: if (rx_ferr) begin
                    if (rx_s) begin
                        rx_ferr  <= 1'b0;
                        rx_state <= RX_IDLE;
                    end
                end else if (baud_en) begin
                    if (rx_os == OS_LAST) begin
                        if (rx_s) begin
                            rx_buf   <= rx_shift;
                            rda      <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else rx_os <= rx_os + 1'b1;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spart.sv
// Directed scoreboard bench for spart: bus decode, baud timing, TX/RX framing, overrun and reset.
module tb_spart;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, iocs, iorw, rxd, tb_drive;
    logic [1:0] ioaddr;
    logic [7:0] tb_data;
    wire  [7:0] databus;
    logic       rda, tbr, txd;

    int n_tests = 0;
    int n_fail  = 0;
    int bit_cyc = 32;
    logic exp_tx_bits[$];
    logic [7:0] exp_rx[$];
    logic tx_busy = 1'b0;

    assign databus = tb_drive ? tb_data : 8'bzzzz_zzzz;
    always #5 clk = ~clk;

    spart dut (
        .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
    );

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All bus tasks are entered and left on a falling clock edge.
    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        iocs = 1'b1; iorw = 1'b0; ioaddr = addr; tb_data = data; tb_drive = 1'b1;
        if (addr == ADDR_BUF) begin
            if (!tx_busy) begin
                tx_busy = 1'b1;
                exp_tx_bits.push_back(1'b0);
                for (int i = 0; i < 8; i++) exp_tx_bits.push_back(data[i]);
                exp_tx_bits.push_back(1'b1);
            end
        end
        @(negedge clk);
        iocs = 1'b0; tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] data, output logic oe);
        iocs = 1'b1; iorw = 1'b1; ioaddr = addr;
        #1;
        data = databus;
        oe = dut.bus_oe;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic measure_en_period(output int cycles);
        int n = 0;
        cycles = -1;
        while (!dut.u_baud.en && n < 2000) begin @(negedge clk); n++; end
        if (n < 2000) begin
            n = 0;
            @(negedge clk);
            n = 1;
            while (!dut.u_baud.en && n < 2000) begin @(negedge clk); n++; end
            if (n < 2000) cycles = n;
        end
    endtask

    task automatic capture_tx_frame(input string tag);
        int n = 0;
        while (txd && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            check_output({tag, "_start_timeout"}, 16'd0, 16'd1);
            exp_tx_bits.delete();
        end else begin
            repeat (bit_cyc / 2 - 1) @(negedge clk);
            for (int b = 0; b < 10; b++) begin
                if (b > 0) repeat (bit_cyc) @(negedge clk);
                if (exp_tx_bits.size() > 0)
                    check_output($sformatf("%s_bit%0d", tag, b), 16'(txd), 16'(exp_tx_bits.pop_front()));
            end
            check_output({tag, "_tbr_mid_stop"}, 16'(tbr), 16'd0);
            n = 0;
            while (!tbr && n < 100) begin @(negedge clk); n++; end
            check_output({tag, "_tbr_delay"}, 16'(n), 16'd17);
        end
        tx_busy = 1'b0;
    endtask

    task automatic apply_rx_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        if (stop_bit) exp_rx.push_back(data);
        for (int b = 0; b < 10; b++) begin
            rxd = frame[b];
            repeat (bit_cyc) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (bit_cyc) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd;
        logic       oe;
        int         per;
        int         n;
        logic       went_low;
        logic [7:0] last_good;

        rst_n = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; rxd = 1'b1;
        tb_drive = 1'b0; tb_data = 8'h00;
        repeat (3) @(negedge clk);
        check_output("rst_txd", 16'(txd), 16'd1);
        check_output("rst_tbr", 16'(tbr), 16'd1);
        check_output("rst_rda", 16'(rda), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: reset register values and default baud period
        bus_read(ADDR_STAT, rd, oe);
        check_output("t1_status", 16'(rd), 16'h02);
        check_output("t1_status_oe", 16'(oe), 16'd1);
        bus_read(ADDR_BUF, rd, oe);
        check_output("t1_rxbuf", 16'(rd), 16'h00);
        bus_read(ADDR_DBL, rd, oe);
        check_output("t1_dbl_read_z", 16'(oe), 16'd0);
        check_output("t1_idle_z", 16'(dut.bus_oe), 16'd0);
        measure_en_period(per);
        check_output("t1_en_period", 16'(per), 16'd326);

        // Test 2: divisor 1 and transmit 8'hA5
        bus_write(ADDR_DBL, 8'h01);
        bus_write(ADDR_DBH, 8'h00);
        measure_en_period(per);
        check_output("t2_en_period", 16'(per), 16'd2);
        bus_write(ADDR_BUF, 8'hA5);
        check_output("t2_tbr_cleared", 16'(tbr), 16'd0);
        capture_tx_frame("t2_tx");

        // Test 3: receive 8'h3C, read it back, rda clears
        bus_write(ADDR_DBL, 8'h01);
        apply_rx_frame(8'h3C, 1'b1);
        check_output("t3_rda_set", 16'(rda), 16'd1);
        bus_read(ADDR_BUF, rd, oe);
        check_output("t3_rx_data", 16'(rd), 16'(exp_rx.pop_front()));
        check_output("t3_rda_cleared", 16'(rda), 16'd0);
        last_good = 8'h3C;

        // Test 4: short low glitch is rejected as a false start
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (64) @(negedge clk);
        check_output("t4_rda", 16'(rda), 16'd0);
        check_output("t4_rx_idle", 16'(dut.rx_state == RX_IDLE), 16'd1);

        // Test 5: framing error keeps the buffer, then overrun overwrites it
        apply_rx_frame(8'h55, 1'b0);
        check_output("t5_ferr_rda", 16'(rda), 16'd0);
        bus_read(ADDR_BUF, rd, oe);
        check_output("t5_ferr_buf", 16'(rd), 16'(last_good));
        apply_rx_frame(8'h11, 1'b1);
        apply_rx_frame(8'h22, 1'b1);
        check_output("t5_overrun_rda", 16'(rda), 16'd1);
        bus_read(ADDR_STAT, rd, oe);
        check_output("t5_status", 16'(rd), 16'h03);
        bus_read(ADDR_BUF, rd, oe);
        while (exp_rx.size() > 1) void'(exp_rx.pop_front());
        check_output("t5_overrun_buf", 16'(rd), 16'(exp_rx.pop_front()));

        // Test 6: write while busy is dropped; reset mid-frame
        bus_write(ADDR_BUF, 8'h12);
        bus_write(ADDR_BUF, 8'h34);
        capture_tx_frame("t6_tx");
        went_low = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (!txd) went_low = 1'b1;
        end
        check_output("t6_no_second_frame", 16'(went_low), 16'd0);

        apply_rx_frame(8'h77, 1'b1);
        check_output("t6_rda_before_rst", 16'(rda), 16'd1);
        bus_write(ADDR_BUF, 8'h5A);
        n = 0;
        while (txd && n < 3000) begin @(negedge clk); n++; end
        repeat (112) @(negedge clk);
        check_output("t6_txd_bit2", 16'(txd), 16'd0);
        check_output("t6_tbr_busy", 16'(tbr), 16'd0);
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_txd", 16'(txd), 16'd1);
        check_output("t6_rst_tbr", 16'(tbr), 16'd1);
        check_output("t6_rst_rda", 16'(rda), 16'd0);
        exp_tx_bits.delete();
        exp_rx.delete();
        tx_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(ADDR_BUF, rd, oe);
        check_output("t6_rst_rxbuf", 16'(rd), 16'h00);
        measure_en_period(per);
        check_output("t6_rst_en_period", 16'(per), 16'd326);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
